// File: rtl/led_pkg.sv
// Shared mode/direction encodings and per-mode initial LED patterns.
package led_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_BLINK  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BINARY = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [LED_W-1:0] INIT_BLINK  = 8'h00;
  localparam logic [LED_W-1:0] INIT_CHASE  = 8'h01;
  localparam logic [LED_W-1:0] INIT_BOUNCE = 8'h01;
  localparam logic [LED_W-1:0] INIT_BINARY = 8'h00;

  // Pattern loaded when a mode is entered.
  function automatic logic [LED_W-1:0] init_led(input mode_e m);
    logic [LED_W-1:0] v;
    case (m)
      MODE_BLINK:  v = INIT_BLINK;
      MODE_CHASE:  v = INIT_CHASE;
      MODE_BOUNCE: v = INIT_BOUNCE;
      default:     v = INIT_BINARY;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/step_divider.sv
// Divides the 1 ms tick down to one pattern step every PERIOD_MS ticks.
module step_divider #(
  parameter int unsigned PERIOD_MS = 250,
  parameter int unsigned CNT_W     = 16
) (
  input  logic clk,
  input  logic rstN,
  input  logic iTick1ms,
  input  logic iClear,
  output logic oStepPulse
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_MS - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  // Next count; the step pulse is combinational so the consumer acts on the same edge.
  always_comb begin
    at_last    = (cnt_q == LAST);
    oStepPulse = iTick1ms && at_last && !iClear;
    cnt_d      = cnt_q;
    if (iClear) begin
      cnt_d = '0;
    end else if (iTick1ms) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Tick counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: blink, chase, bounce and binary count, stepped by a divided 1 ms tick.
module led_pattern_seq
  import led_pkg::*;
#(
  parameter int unsigned PERIOD_MS = 250,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              iTick1ms,
  input  logic              iModeNext,
  output logic [LED_W-1:0]  oLed,
  output logic [MODE_W-1:0] oMode,
  output logic              oStep
);

  mode_e            mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             step_q, step_d;
  logic             step_c;
  logic [LED_W-1:0] shifted;

  step_divider #(
    .PERIOD_MS (PERIOD_MS),
    .CNT_W     (CNT_W)
  ) u_step_divider (
    .clk        (clk),
    .rstN       (rstN),
    .iTick1ms   (iTick1ms),
    .iClear     (iModeNext),
    .oStepPulse (step_c)
  );

  // Next-state: a mode advance wins over a coincident step.
  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    led_d   = led_q;
    step_d  = 1'b0;
    shifted = '0;
    if (iModeNext) begin
      mode_d = mode_e'(mode_q + 2'd1);
      led_d  = init_led(mode_d);
      dir_d  = DIR_LEFT;
    end else if (step_c) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_BLINK:  led_d = ~led_q;
        MODE_CHASE:  led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            shifted = {led_q[LED_W-2:0], 1'b0};
            if (shifted == 8'h80) dir_d = DIR_RIGHT;
          end else begin
            shifted = {1'b0, led_q[LED_W-1:1]};
            if (shifted == 8'h01) dir_d = DIR_LEFT;
          end
          led_d = shifted;
        end
        default:     led_d = led_q + 8'd1;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      mode_q <= MODE_BLINK;
      dir_q  <= DIR_LEFT;
      led_q  <= INIT_BLINK;
      step_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      step_q <= step_d;
    end
  end

  assign oLed  = led_q;
  assign oMode = mode_q;
  assign oStep = step_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Scoreboard bench: two instances (PERIOD_MS=4 and PERIOD_MS=1) against a step-count reference model.
module tb_led_pattern_seq;

  typedef struct packed {
    logic [7:0] led;
    logic [1:0] mode;
    logic       step;
  } obs_t;

  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       tick = 1'b0;
  logic       mnext = 1'b0;
  logic [7:0] led_a, led_b;
  logic [1:0] mode_a, mode_b;
  logic       step_a, step_b;

  int errors = 0;
  int checks = 0;
  exp_t exp_q[$];

  int m_mode[2];
  int m_ticks[2];
  int m_n[2];
  bit m_step[2];
  int per[2];

  always #5 clk = ~clk;

  led_pattern_seq #(.PERIOD_MS(4), .CNT_W(16)) dut_a (
    .clk(clk), .rstN(rstN), .iTick1ms(tick), .iModeNext(mnext),
    .oLed(led_a), .oMode(mode_a), .oStep(step_a)
  );

  led_pattern_seq #(.PERIOD_MS(1), .CNT_W(16)) dut_b (
    .clk(clk), .rstN(rstN), .iTick1ms(tick), .iModeNext(mnext),
    .oLed(led_b), .oMode(mode_b), .oStep(step_b)
  );

  // Pattern after n steps since entering a mode, from the mode's definition.
  function automatic logic [7:0] pattern(input int mode, input int n);
    int pos;
    int b;
    case (mode)
      0: return (n % 2 == 1) ? 8'hFF : 8'h00;
      1: return 8'(1 << (n % 8));
      2: begin
        pos = n % 14;
        b   = (pos <= 7) ? pos : 14 - pos;
        return 8'(1 << b);
      end
      default: return 8'(n % 256);
    endcase
  endfunction

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.led  = pattern(m_mode[i], m_n[i]);
    o.mode = 2'(m_mode[i]);
    o.step = m_step[i];
    return o;
  endfunction

  // Apply one cycle of stimulus and queue the expected post-edge outputs.
  task automatic drive(input bit t, input bit nx, input bit r);
    exp_t e;
    @(negedge clk);
    tick  = t;
    mnext = nx;
    rstN  = r;
    for (int i = 0; i < 2; i++) begin
      m_step[i] = 1'b0;
      if (!r) begin
        m_mode[i] = 0; m_ticks[i] = 0; m_n[i] = 0;
      end else if (nx) begin
        m_mode[i] = (m_mode[i] + 1) % 4; m_ticks[i] = 0; m_n[i] = 0;
      end else if (t) begin
        m_ticks[i]++;
        if (m_ticks[i] == per[i]) begin
          m_ticks[i] = 0; m_n[i]++; m_step[i] = 1'b1;
        end
      end
    end
    e.a = model_obs(0);
    e.b = model_obs(1);
    exp_q.push_back(e);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 1'b1);
  endtask

  // Monitor: compares every post-edge output against the queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({led_a, mode_a, step_a} !== e.a) begin
        errors++;
        $display("FAIL p4 t=%0t got led=%h mode=%0d step=%0b exp led=%h mode=%0d step=%0b",
                 $time, led_a, mode_a, step_a, e.a.led, e.a.mode, e.a.step);
      end
      checks++;
      if ({led_b, mode_b, step_b} !== e.b) begin
        errors++;
        $display("FAIL p1 t=%0t got led=%h mode=%0d step=%0b exp led=%h mode=%0d step=%0b",
                 $time, led_b, mode_b, step_b, e.b.led, e.b.mode, e.b.step);
      end
    end
  end

  initial begin
    per[0] = 4;
    per[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_ticks[i] = 0; m_n[i] = 0; m_step[i] = 1'b0;
    end

    // Reset.
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    // Blink: 8 ticks, plus idle cycles where the counter must hold.
    ticks(3);
    drive(1'b0, 1'b0, 1'b1);
    ticks(5);
    drive(1'b0, 1'b0, 1'b1);
    // Chase: 36 ticks (9 steps, wraps 80 -> 01 -> 02).
    drive(1'b0, 1'b1, 1'b1);
    ticks(36);
    // Bounce: 15 steps across both turnarounds.
    drive(1'b0, 1'b1, 1'b1);
    ticks(60);
    // Binary: 255 steps to FF, one more wraps to 00.
    drive(1'b0, 1'b1, 1'b1);
    ticks(1020);
    ticks(4);
    // Back-to-back advances: binary -> blink -> chase.
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    // Chase to 04, three more ticks, then advance coincident with the step tick.
    ticks(11);
    drive(1'b1, 1'b1, 1'b1);
    ticks(4);
    // Binary to 5A, then reset with advance and tick asserted.
    drive(1'b0, 1'b1, 1'b1);
    ticks(360);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    ticks(4);

    // Randomized phase.
    for (int k = 0; k < 3000; k++) begin
      drive(1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0),
            1'($urandom_range(0, 199) != 0));
    end

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
